hazard_stall_unit: RTL
======================

HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 Parameter: MDU_LAT, default 4, multiply/divide latency in cycles; legal range 1..15.
REQ-002 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 IDRegRs  input  5  rs field of the instruction in ID.
REQ-005 IDRegRt  input  5  rt field of the instruction in ID.
REQ-006 IDUsesRt  input  1  ID instruction reads rt as a source.
REQ-007 IDBranch  input  1  ID instruction is a branch resolved in ID.
REQ-008 IDUsesHiLo  input  1  ID instruction reads HI/LO (mfhi/mflo).
REQ-009 EXRegDst  input  5  destination register of the instruction in EX.
REQ-010 EXMemRead  input  1  EX instruction is a load.
REQ-011 mdu_start  input  1  EX instruction issues a multiply/divide this cycle.
REQ-012 PCWrite  output  1  1 = PC may advance.
REQ-013 IFIDWrite  output  1  1 = IF/ID register may load.
REQ-014 IDEXFlush  output  1  1 = insert a bubble into ID/EX.
REQ-015 mdu_busy  output  1  1 = multiply/divide result not yet available.
REQ-016 stall_cnt  output  16  stall cycle count; present only with HAZARD_STALL_CNT_EN.

Function
REQ-017 match_rs = (EXRegDst != 0) && (EXRegDst == IDRegRs); match_rt = (EXRegDst != 0) && IDUsesRt && (EXRegDst == IDRegRt).
REQ-018 load_use = EXMemRead && (match_rs || match_rt).
REQ-019 FSM states: RUN, BR_WAIT.
REQ-020 RUN: load_use && IDBranch -> stall this cycle, next state BR_WAIT.
REQ-021 RUN: load_use && !IDBranch -> stall this cycle, remain RUN (single bubble; MEM forwarding covers the next cycle).
REQ-022 BR_WAIT: stall unconditionally for one cycle, next state RUN; inputs are ignored for the state transition.
REQ-023 MDU counter, 4 bits: mdu_start loads MDU_LAT; otherwise it decrements when nonzero and holds at 0.
REQ-024 mdu_start while the counter is nonzero reloads MDU_LAT (restart); decrement and reload never both apply.
REQ-025 mdu_busy = (counter != 0), registered-state based with no combinational path from mdu_start.
REQ-026 hilo_stall = IDUsesHiLo && mdu_busy.
REQ-027 stall = load_use || (state == BR_WAIT) || hilo_stall.
REQ-028 Outputs are combinational from state and inputs with zero latency: PCWrite = !stall, IFIDWrite = !stall, IDEXFlush = stall.
REQ-029 Simultaneous hazard causes assert a single stall; the FSM and counter advance independently in the same cycle.
REQ-030 A stalled ID instruction re-evaluates every cycle; a stall ends in the first cycle with no active cause.

Reset
REQ-031 While rst_n = 0: state = RUN, counter = 0, stall_cnt = 0, mdu_busy = 0.
REQ-032 While rst_n = 0, PCWrite = 1, IFIDWrite = 1 and IDEXFlush = 0, regardless of other inputs.
REQ-033 Reset asserted mid-stall, including in BR_WAIT or with the counter nonzero, aborts the stall immediately; no stall persists after release.

Configuration
REQ-034 Macro HAZARD_STALL_CNT_EN defined: stall_cnt increments by 1 on every clock with stall = 1 and saturates at 16'hFFFF.
REQ-035 Macro HAZARD_STALL_CNT_EN undefined: the stall_cnt port and its register are absent; all other behaviour is identical.

Verification
REQ-036 EXMemRead=1, EXRegDst=8, IDRegRs=8, IDBranch=0 for one cycle -> PCWrite=0, IDEXFlush=1 for exactly 1 cycle; state stays RUN.
REQ-037 EXMemRead=1, EXRegDst=9, IDRegRt=9, IDUsesRt=1, IDBranch=1 -> stall for 2 consecutive cycles (RUN -> BR_WAIT -> RUN), then PCWrite=1.
REQ-038 EXRegDst=0, IDRegRs=0, EXMemRead=1 -> no stall; IDUsesRt=0 with an rt match -> no stall.
REQ-039 MDU_LAT=4, mdu_start pulse, then IDUsesHiLo=1 -> mdu_busy=1 for 4 cycles and stall for 4 cycles; mdu_start pulsed again at count 2 -> busy extends to 4 cycles from the reload.
REQ-040 rst_n driven low while in BR_WAIT with the counter at 3 -> outputs immediately PCWrite=1, IDEXFlush=0, mdu_busy=0; no stall after release.
REQ-041 With HAZARD_STALL_CNT_EN defined: 5 stall cycles -> stall_cnt=5; forced to saturate -> holds 16'hFFFF.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// Load-use / branch / HI-LO hazard detection with stall generation for a 5-stage pipeline.
// Optional stall cycle counter enabled by defining HAZARD_STALL_CNT_EN.
module hazard_stall_unit #(
   parameter int unsigned MDU_LAT = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] IDRegRs,
   input  logic [4:0] IDRegRt,
   input  logic       IDUsesRt,
   input  logic       IDBranch,
   input  logic       IDUsesHiLo,
   input  logic [4:0] EXRegDst,
   input  logic       EXMemRead,
   input  logic       mdu_start,
   output logic       PCWrite,
   output logic       IFIDWrite,
   output logic       IDEXFlush,
   output logic       mdu_busy
`ifdef HAZARD_STALL_CNT_EN
   ,
   output logic [15:0] stall_cnt
`endif
);

   localparam logic [3:0] LAT = 4'(MDU_LAT);

   typedef enum logic {RUN, BR_WAIT} state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_mdu_cnt;
   logic       w_match_rs;
   logic       w_match_rt;
   logic       w_load_use;
   logic       w_hilo_stall;
   logic       w_stall;

   assign w_match_rs   = (EXRegDst != 5'd0) && (EXRegDst == IDRegRs);
   assign w_match_rt   = (EXRegDst != 5'd0) && IDUsesRt && (EXRegDst == IDRegRt);
   assign w_load_use   = EXMemRead && (w_match_rs || w_match_rt);
   assign mdu_busy     = (r_mdu_cnt != 4'd0);
   assign w_hilo_stall = IDUsesHiLo && mdu_busy;

   // Gate with rst_n so input-driven causes cannot stall while reset is held.
   assign w_stall   = rst_n && (w_load_use || (r_state == BR_WAIT) || w_hilo_stall);
   assign PCWrite   = !w_stall;
   assign IFIDWrite = !w_stall;
   assign IDEXFlush = w_stall;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         RUN:     if (w_load_use && IDBranch) w_state_nxt = BR_WAIT;
         BR_WAIT: w_state_nxt = RUN;
         default: w_state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= RUN;
      else        r_state <= w_state_nxt;
   end

   // A start while busy restarts the full latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 r_mdu_cnt <= 4'd0;
      else if (mdu_start)         r_mdu_cnt <= LAT;
      else if (r_mdu_cnt != 4'd0) r_mdu_cnt <= r_mdu_cnt - 4'd1;
   end

`ifdef HAZARD_STALL_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                  stall_cnt <= 16'd0;
      else if (w_stall && stall_cnt != 16'hFFFF)   stall_cnt <= stall_cnt + 16'd1;
   end
`endif

endmodule
